// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front-end: opcode map, FSM states
// and the buffered command record.
package alu_pkg;

    localparam logic [3:0] OP_INC_A  = 4'h0;
    localparam logic [3:0] OP_INC_B  = 4'h1;
    localparam logic [3:0] OP_PASS_A = 4'h2;
    localparam logic [3:0] OP_PASS_B = 4'h3;
    localparam logic [3:0] OP_DEC_A  = 4'h4;
    localparam logic [3:0] OP_MUL    = 4'h5;
    localparam logic [3:0] OP_ADD    = 4'h6;
    localparam logic [3:0] OP_SUB    = 4'h7;
    localparam logic [3:0] OP_NOT_A  = 4'h8;
    localparam logic [3:0] OP_NOT_B  = 4'h9;
    localparam logic [3:0] OP_AND    = 4'hA;
    localparam logic [3:0] OP_OR     = 4'hB;
    localparam logic [3:0] OP_XOR    = 4'hC;
    localparam logic [3:0] OP_XNOR   = 4'hD;
    localparam logic [3:0] OP_NAND   = 4'hE;
    localparam logic [3:0] OP_NOR    = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_RESP
    } drv_state_e;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       chain;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// Count-based synchronous FIFO; full/empty come straight from the registered
// occupancy, so a push is refused while full even if a pop happens that cycle.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Command front-end for the 4-bit ALU: buffers commands, drives registered
// ALU operands, samples the result and hands it back over valid/ready.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [3:0]        cmd_a,
    input  logic [3:0]        cmd_b,
    input  logic              cmd_chain,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    output logic [3:0]        alu_sel,
    input  logic signed [7:0] alu_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic signed [7:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_neg,
    output logic              busy
);

    drv_state_e        state_q;
    logic [3:0]        alu_a_q;
    logic [3:0]        alu_b_q;
    logic [3:0]        alu_sel_q;
    logic              rsp_valid_q;
    logic signed [7:0] rsp_data_q;
    logic signed [7:0] last_y_q;

    cmd_t wr_cmd;
    cmd_t rd_cmd;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    assign wr_cmd = '{op: cmd_op, a: cmd_a, b: cmd_b, chain: cmd_chain};
    assign push   = cmd_valid && !fifo_full;
    assign pop    = (state_q == ST_DRIVE);

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_cmd),
        .rdata_o (rd_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            last_y_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) state_q <= ST_DRIVE;
                end
                ST_DRIVE: begin
                    alu_sel_q <= rd_cmd.op;
                    alu_b_q   <= rd_cmd.b;
                    alu_a_q   <= rd_cmd.chain ? last_y_q[3:0] : rd_cmd.a;
                    state_q   <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    rsp_data_q  <= alu_y;
                    last_y_q    <= alu_y;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    // A push landing on the handshake edge counts toward going straight back to DRIVE.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= (!fifo_empty || push) ? ST_DRIVE : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = !fifo_full;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = (rsp_data_q == '0);
    assign rsp_neg   = rsp_data_q[7];
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Sequential command front-end for the 4-bit ALU: accepts opcode/operand commands over a valid/ready interface, buffers them in a small FIFO, drives the ALU's `a`/`b`/`sel` inputs from registers, samples the 8-bit signed result and returns it over a valid/ready response channel. It is the initiator of the ALU operand/opcode interface and sits between a host/testbench sequencer and one ALU instance. An optional chain mode feeds the previous result back as operand A, so multi-step expressions can be issued without a host round-trip.

## Interface
- `FIFO_DEPTH`, default 4, number of buffered commands; must be a power of two, ≥ 2.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: FIFO can accept; equals !full.
- `cmd_op` input 4: ALU opcode. Bit 3 = 0 selects arithmetic, bit 3 = 1 selects logic.
- `cmd_a` input 4: operand A.
- `cmd_b` input 4: operand B.
- `cmd_chain` input 1: if 1, replace operand A with the low nibble of the last captured result.
- `alu_a` output 4: registered operand A to the ALU.
- `alu_b` output 4: registered operand B to the ALU.
- `alu_sel` output 4: registered opcode to the ALU.
- `alu_y` input 8: signed ALU result; combinational from `alu_a`/`alu_b`/`alu_sel`.
- `rsp_valid` output 1: result available.
- `rsp_ready` input 1: consumer accepts the result.
- `rsp_data` output 8: captured `alu_y`, verbatim.
- `rsp_zero` output 1: `rsp_data` == 0.
- `rsp_neg` output 1: `rsp_data[7]`.
- `busy` output 1: FSM not in IDLE, or FIFO not empty.

## Operation
- Push: a command enters the FIFO on a rising edge with `cmd_valid & cmd_ready`. No bypass path. A push is never accepted when the FIFO is full, even if a pop happens in the same cycle.
- FSM states: IDLE, DRIVE, SAMPLE, RESP.
  - IDLE: if the FIFO is not empty, go to DRIVE.
  - DRIVE: pop the head entry. Load `alu_sel` = op and `alu_b` = b. Load `alu_a` = chain ? last_y[3:0] : a. Go to SAMPLE.
  - SAMPLE: ALU inputs held stable. Capture `alu_y` into `rsp_data` and into `last_y`. Go to RESP.
  - RESP: hold `rsp_valid` = 1 and hold `rsp_data`. When `rsp_ready` = 1: go to DRIVE if the FIFO is not empty after this cycle's push, otherwise go to IDLE.
- `alu_a`, `alu_b` and `alu_sel` keep their last values outside DRIVE.
- `rsp_data` is not reinterpreted. The ALU produces a 4-bit signed value sign-extended to 8 bits, so arithmetic wraps modulo 16 and logic results with bit 3 set read as negative (e.g. 0x8 appears as 0xF8).
- `last_y` resets to 0. Chain mode before any completed operation uses 0 as operand A.
- Opcodes are not checked. All 16 values are valid ALU operations.

## Timing
- Reset values: `alu_a` = `alu_b` = `alu_sel` = 0; `rsp_valid` = 0; `rsp_data` = 0; `rsp_zero` = 1; `rsp_neg` = 0; `busy` = 0; `cmd_ready` = 1; FIFO empty; FSM in IDLE.
- Asserting `rst_n` low mid-operation immediately clears all state. Buffered and in-flight commands are discarded and no response is produced.
- Latency, push to empty idle block at edge 0:
  - DRIVE at cycle 1, ALU inputs valid after edge 2.
  - SAMPLE at cycle 2.
  - `rsp_valid` high after edge 3.
  - Minimum 3 cycles.
- Throughput with `rsp_ready` tied high: one result per 3 cycles (RESP → DRIVE → SAMPLE → RESP).
- `rsp_valid` never drops without a handshake. `rsp_data`, `rsp_zero` and `rsp_neg` are stable while `rsp_valid` & !`rsp_ready`.
- `cmd_ready` is registered-count based: it deasserts the cycle after the FIFO becomes full and reasserts the cycle after a pop.

## Structure
- Shared package `alu_pkg`:
  - 4-bit opcode localparams: OP_INC_A, OP_INC_B, OP_PASS_A, OP_PASS_B, OP_DEC_A, OP_MUL, OP_ADD, OP_SUB, OP_NOT_A, OP_NOT_B, OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_NAND, OP_NOR.
  - FSM state typedef.
  - Command struct {op, a, b, chain}, 13 bits.
- One sub-module `alu_cmd_fifo`: synchronous FIFO, parameterized depth and width, with full/empty outputs. The driver instantiates it with width 13.
- Top-level tests wire `alu_cmd_driver` to the existing ALU.

## Test plan
- Reset then push op=0110, a=3, b=2 → `rsp_valid` 3 cycles later, `rsp_data` = 0x05, `rsp_zero` = 0, `rsp_neg` = 0.
- Push op=0111, a=2, b=5 → `rsp_data` = 0xFD, `rsp_neg` = 1. Then op=0110, a=7, b=1 → 0xF8 (wrap).
- Push op=1010, a=0xC, b=0xA → `rsp_data` = 0xF8. Then op=1100, a=5, b=5 → 0x00, `rsp_zero` = 1.
- Push op=0110, a=2, b=3, then op=0110, b=4, chain=1, then op=0101, b=2, chain=1 → responses 0x05, 0xF9, 0x02 (9 wraps to -7 = 0xF9; 9 × 2 = 18 wraps to 2), in order.
- Hold `rsp_ready` = 0 and push 6 commands with FIFO_DEPTH = 4 → `cmd_ready` low after 4 are buffered beyond the in-flight one. `rsp_data` stays stable while stalled. All 5 accepted commands complete in order after release. No loss or duplication.
- Pull `rst_n` low during SAMPLE with 2 commands buffered → all outputs return to reset values immediately and no response appears after release.
